// File: rtl/trace_fifo_ctrl.sv
// trace_fifo_ctrl: single-clock trace-word FIFO controller around an external
// one-cycle-latency RAM, with a 2-entry output skid buffer and a valid/ready output.
// Latency: 3 cycles from din_valid into an empty FIFO to dout_valid. Sustains 1 word/clk.
// Backpressure: dout_ready stalls the output. Writes are never stalled.
// A write that arrives while the RAM is full is dropped and counted in ovf_count.
// Ports:
//   clk/rst_n                  clock and async active-low reset
//   flush                      synchronous clear of all buffered data
//   din/din_valid              input stream
//   dout/dout_valid/dout_ready output stream
//   full/empty/level/ovf_count status
//   ram_*                      RAM write/read port
module trace_fifo_ctrl #(
  parameter int addr_width = 8,
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [data_width-1:0] din,
  input  logic                  din_valid,
  output logic [data_width-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  full,
  output logic                  empty,
  output logic [addr_width+1:0] level,
  output logic [15:0]           ovf_count,
  output logic [data_width-1:0] ram_din,
  output logic [addr_width-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_raddr,
  input  logic [data_width-1:0] ram_dout
);

  logic [addr_width-1:0] wptr, rptr;
  logic [addr_width:0]   ram_cnt;
  logic                  rd_pend;
  logic [1:0]            skid_cnt;
  logic [data_width-1:0] skid0, skid1;

  logic       wr_acc;
  logic       pop;
  logic       rd_issue;
  logic [2:0] committed;

  // ram_cnt ranges 0..D, so its top bit is set only when the RAM holds D words.
  assign full       = ram_cnt[addr_width];
  assign dout_valid = (skid_cnt != 2'd0);
  assign dout       = skid0;

  assign wr_acc = din_valid && !full && !flush;
  assign pop    = dout_valid && dout_ready && !flush;

  // This counts the skid slots already spoken for after this cycle's pop.
  // A new read is issued only if its data will still have a slot when it lands.
  assign committed = 3'(skid_cnt) + 3'(rd_pend) - 3'(pop);
  assign rd_issue  = (ram_cnt != '0) && (committed < 3'd2) && !flush;

  // The write strobe is qualified with rst_n so that the RAM write port goes idle
  // the moment reset asserts, not at the next clock.
  assign ram_we    = wr_acc && rst_n;
  assign ram_din   = (wr_acc && rst_n) ? din : '0;
  assign ram_waddr = wptr;
  assign ram_raddr = rptr;

  assign level = (addr_width+2)'(ram_cnt) + (addr_width+2)'(rd_pend)
               + (addr_width+2)'(skid_cnt);
  assign empty = (level == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      rd_pend   <= 1'b0;
      skid_cnt  <= 2'd0;
      skid0     <= '0;
      skid1     <= '0;
      ovf_count <= '0;
    end else if (flush) begin
      // Clearing rd_pend discards the word still coming out of the RAM.
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      rd_pend   <= 1'b0;
      skid_cnt  <= 2'd0;
      ovf_count <= '0;
    end else begin
      if (wr_acc)   wptr <= wptr + 1'b1;
      if (rd_issue) rptr <= rptr + 1'b1;

      case ({wr_acc, rd_issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase

      rd_pend <= rd_issue;

      if (din_valid && full && (ovf_count != 16'hFFFF))
        ovf_count <= ovf_count + 16'd1;

      // skid0 is always the head. The issue rule guarantees that a capture never
      // meets a skid buffer that is full and not popping.
      if (rd_pend && pop) begin
        if (skid_cnt == 2'd2) begin
          skid0 <= skid1;
          skid1 <= ram_dout;
        end else begin
          skid0 <= ram_dout;
        end
      end else if (pop) begin
        skid0 <= skid1;
      end else if (rd_pend) begin
        if (skid_cnt == 2'd0) skid0 <= ram_dout;
        else                  skid1 <= ram_dout;
      end

      skid_cnt <= skid_cnt + rd_pend - pop;
    end
  end

endmodule
